// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared system bus.
// It grants one master at a time and follows each transaction through its
// begin/end handshake. A grantee that never starts loses the bus, and a hung
// transaction is aborted with a one-cycle timeout_error pulse. Every output
// is driven straight from a register.
module bus_arbiter #(
    parameter int NUM_MASTERS   = 4,
    parameter int GRANT_TIMEOUT = 16,
    parameter int BUS_TIMEOUT   = 1024
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_MASTERS-1:0]         request,
    input  logic                           begin_transaction,
    input  logic                           end_transaction,
    input  logic                           error,
    output logic [NUM_MASTERS-1:0]         granted,
    output logic [$clog2(NUM_MASTERS)-1:0] active_master,
    output logic                           bus_busy,
    output logic                           timeout_error
);

    localparam int IDX_W       = $clog2(NUM_MASTERS);
    localparam int MAX_TIMEOUT = (GRANT_TIMEOUT > BUS_TIMEOUT) ? GRANT_TIMEOUT : BUS_TIMEOUT;
    localparam int CNT_W       = $clog2(MAX_TIMEOUT) + 1;

    // The counter is cleared in the first cycle of each wait, so the limit is the last allowed count.
    localparam logic [CNT_W-1:0] GRANT_LIMIT = CNT_W'(GRANT_TIMEOUT - 1);
    // The begin-strobe cycle is the first cycle of the transaction, so BUSY may add BUS_TIMEOUT-1 more cycles.
    localparam logic [CNT_W-1:0] BUS_LIMIT   = CNT_W'(BUS_TIMEOUT - 2);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic [IDX_W:0]         NUM_M      = (IDX_W + 1)'(NUM_MASTERS);
    localparam logic [IDX_W-1:0]       LAST_RESET = IDX_W'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT    = NUM_MASTERS'(1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_WAIT,
        BUSY,
        RELEASE
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        counter_q;
    logic [IDX_W-1:0]        lastGrant_q;
    logic [NUM_MASTERS-1:0]  granted_q;
    logic [IDX_W-1:0]        activeMaster_q;
    logic                    busBusy_q;
    logic                    timeoutError_q;

    logic [IDX_W-1:0]        winner_d;
    logic [IDX_W:0]          scanSum;
    logic [CNT_W-1:0]        counterInc_d;
    logic                    anyRequest;
    logic                    grantLost;

    // Round-robin pick: scan from last+NUM_MASTERS down to last+1 so the nearest requester after the pointer is kept.
    always_comb begin
        winner_d = '0;
        scanSum  = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            scanSum = {1'b0, lastGrant_q} + (IDX_W + 1)'(i);
            if (scanSum >= NUM_M) begin
                scanSum = scanSum - NUM_M;
            end
            if (request[scanSum[IDX_W-1:0]]) begin
                winner_d = scanSum[IDX_W-1:0];
            end
        end
    end

    // Helper terms: a saturating counter increment and a check that the current grantee still requests.
    always_comb begin
        counterInc_d = (counter_q == CNT_MAX) ? counter_q : counter_q + CNT_ONE;
        anyRequest   = |request;
        grantLost    = ~request[activeMaster_q];
    end

    // Arbiter FSM: state, round-robin pointer, wait counter and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            counter_q      <= '0;
            lastGrant_q    <= LAST_RESET;
            granted_q      <= '0;
            activeMaster_q <= '0;
            busBusy_q      <= 1'b0;
            timeoutError_q <= 1'b0;
        end else begin
            timeoutError_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (anyRequest) begin
                        state_q        <= GRANT_WAIT;
                        counter_q      <= '0;
                        lastGrant_q    <= winner_d;
                        granted_q      <= ONE_HOT << winner_d;
                        activeMaster_q <= winner_d;
                        busBusy_q      <= 1'b1;
                    end
                end
                GRANT_WAIT: begin
                    counter_q <= counterInc_d;
                    if (begin_transaction && (end_transaction || error)) begin
                        state_q   <= RELEASE;
                        granted_q <= '0;
                        busBusy_q <= 1'b0;
                    end else if (begin_transaction) begin
                        state_q   <= BUSY;
                        counter_q <= '0;
                    end else if (grantLost || (counter_q == GRANT_LIMIT)) begin
                        state_q   <= RELEASE;
                        granted_q <= '0;
                        busBusy_q <= 1'b0;
                    end
                end
                BUSY: begin
                    counter_q <= counterInc_d;
                    if (end_transaction || error) begin
                        state_q   <= RELEASE;
                        granted_q <= '0;
                        busBusy_q <= 1'b0;
                    end else if (counter_q == BUS_LIMIT) begin
                        state_q        <= RELEASE;
                        granted_q      <= '0;
                        busBusy_q      <= 1'b0;
                        timeoutError_q <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (anyRequest) begin
                        state_q        <= GRANT_WAIT;
                        counter_q      <= '0;
                        lastGrant_q    <= winner_d;
                        granted_q      <= ONE_HOT << winner_d;
                        activeMaster_q <= winner_d;
                        busBusy_q      <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    granted_q <= '0;
                    busBusy_q <= 1'b0;
                end
            endcase
        end
    end

    assign granted       = granted_q;
    assign active_master = activeMaster_q;
    assign bus_busy      = busBusy_q;
    assign timeout_error = timeoutError_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with default parameters (4 masters,
// grant timeout 16, bus timeout 1024). Each step drives one cycle of inputs
// and then compares the registered outputs with hand-computed values.
module tb_bus_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] request;
    logic       begin_transaction;
    logic       end_transaction;
    logic       error;
    logic [3:0] granted;
    logic [1:0] active_master;
    logic       bus_busy;
    logic       timeout_error;

    int checkCount = 0;
    int errorCount = 0;

    int         fairOrder [5] = '{0, 1, 2, 3, 0};
    logic [3:0] fairGrant;
    logic [1:0] fairIndex;

    bus_arbiter #(
        .NUM_MASTERS  (4),
        .GRANT_TIMEOUT(16),
        .BUS_TIMEOUT  (1024)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .request          (request),
        .begin_transaction(begin_transaction),
        .end_transaction  (end_transaction),
        .error            (error),
        .granted          (granted),
        .active_master    (active_master),
        .bus_busy         (bus_busy),
        .timeout_error    (timeout_error)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Present one cycle of inputs; outputs are then looked at 1 ns after the edge that sampled them.
    task automatic applyStimulus(input logic [3:0] req, input logic beg, input logic fin, input logic err);
        request           = req;
        begin_transaction = beg;
        end_transaction   = fin;
        error             = err;
        @(posedge clock);
        #1;
    endtask

    // Compare every output against the expected values for this step.
    task automatic checkOutput(input string tag, input logic [3:0] expGranted, input logic [1:0] expActive,
                               input logic expBusy, input logic expTimeout);
        checkCount++;
        assert (granted === expGranted) else begin
            errorCount++;
            $error("[TB] FAIL %s granted got %b expected %b", tag, granted, expGranted);
        end
        checkCount++;
        assert (active_master === expActive) else begin
            errorCount++;
            $error("[TB] FAIL %s active_master got %0d expected %0d", tag, active_master, expActive);
        end
        checkCount++;
        assert (bus_busy === expBusy) else begin
            errorCount++;
            $error("[TB] FAIL %s bus_busy got %b expected %b", tag, bus_busy, expBusy);
        end
        checkCount++;
        assert (timeout_error === expTimeout) else begin
            errorCount++;
            $error("[TB] FAIL %s timeout_error got %b expected %b", tag, timeout_error, expTimeout);
        end
    endtask

    // Directed sequence covering reset, grant latency, fairness, both timeouts and reset mid-transaction.
    initial begin
        reset             = 1'b1;
        request           = '0;
        begin_transaction = 1'b0;
        end_transaction   = 1'b0;
        error             = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;

        $display("[TB] single master");
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        checkOutput("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        checkOutput("single_wait", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        checkOutput("single_busy", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        checkOutput("single_release", 4'b0000, 2'd2, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("single_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
        checkOutput("idle_end_ignored", 4'b0000, 2'd2, 1'b0, 1'b0);

        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        $display("[TB] fairness");
        applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            fairGrant = 4'b0001 << fairOrder[k];
            fairIndex = 2'(fairOrder[k]);
            checkOutput("fair_grant", fairGrant, fairIndex, 1'b1, 1'b0);
            applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
            checkOutput("fair_busy", fairGrant, fairIndex, 1'b1, 1'b0);
            applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0);
            checkOutput("fair_release", 4'b0000, fairIndex, 1'b0, 1'b0);
            if (k < 4) begin
                applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
            end
        end
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

        $display("[TB] begin and end together");
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        checkOutput("single_cycle_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(4'b0010, 1'b1, 1'b1, 1'b0);
        checkOutput("single_cycle_release", 4'b0000, 2'd1, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

        $display("[TB] error during busy");
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        checkOutput("error_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        checkOutput("error_busy", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1);
        checkOutput("error_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

        $display("[TB] request dropped before begin");
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_release", 4'b0000, 2'd2, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        checkOutput("idle_begin_ignored", 4'b0000, 2'd2, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_after_begin", 4'b0000, 2'd2, 1'b0, 1'b0);

        $display("[TB] grant timeout");
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        checkOutput("gto_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
            checkOutput("gto_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        checkOutput("gto_release", 4'b0000, 2'd1, 1'b0, 1'b0);
        applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0);
        checkOutput("gto_next", 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("gto_next_drop", 4'b0000, 2'd3, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

        $display("[TB] bus timeout");
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        checkOutput("bto_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        checkOutput("bto_busy", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int c = 4; c <= 1025; c++) begin
            applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
            checkOutput("bto_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        checkOutput("bto_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("bto_pulse_end", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("[TB] reset while busy");
        applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_busy", 4'b1000, 2'd3, 1'b1, 1'b0);
        reset = 1'b1;
        applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_cleared", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        checkOutput("rst2_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        reset = 1'b1;
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        checkOutput("rst2_cleared", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0);
        checkOutput("rst2_pointer", 4'b0010, 2'd1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Round-robin arbiter for the shared system bus used by the JTAG bus master (jtag_support) and other bus masters. It drives the per-master granted lines and tracks each transaction through begin/end handshakes on the bus. It reclaims the bus from masters that stall and raises a timeout error when a slave never ends a transaction. Outputs are fully registered.

Parameters:
NUM_MASTERS, 4, number of requesters (2..16)
GRANT_TIMEOUT, 16, cycles a granted master may hold the bus without asserting begin_transaction (>=2)
BUS_TIMEOUT, 1024, cycles a transaction may last before the arbiter forces an error (>=2)

Ports:
clock  input  1  system clock; everything sampled on rising edge
reset  input  1  synchronous, active-high reset
request  input  NUM_MASTERS  bit i = master i requests the bus; held until served
begin_transaction  input  1  bus begin strobe from the active master
end_transaction  input  1  bus end strobe from master or slave
error  input  1  bus error from slave; ends transaction
granted  output  NUM_MASTERS  one-hot grant or all-zero; registered
active_master  output  $clog2(NUM_MASTERS)  index of current grantee; valid while granted!=0
bus_busy  output  1  high in GRANT_WAIT and BUSY
timeout_error  output  1  one-cycle pulse; arbiter aborts a hung transaction, OR-ed into bus error by top level

Behaviour:
- Reset: granted=0, active_master=0, bus_busy=0, timeout_error=0, state=IDLE, counter=0, rr pointer last=NUM_MASTERS-1 (master 0 wins first).
- Selection: first set request bit scanning last+1, last+2, ... modulo NUM_MASTERS. On grant, last becomes the winner.
- IDLE: if request!=0, register granted=onehot(winner) and active_master=winner, clear counter, go to GRANT_WAIT. Grant appears 1 cycle after request is sampled.
- GRANT_WAIT: counter increments each cycle.
  - begin_transaction=1: go to BUSY and clear counter.
  - begin and end (or error) in the same cycle: single-cycle transaction, go to RELEASE.
  - Grantee request drops without begin: go to RELEASE.
  - counter==GRANT_TIMEOUT-1 without begin: go to RELEASE. No error pulse.
- BUSY: counter increments each cycle.
  - end_transaction or error: go to RELEASE.
  - counter==BUS_TIMEOUT-1: timeout_error=1 for exactly one cycle (the cycle the state is RELEASE), then go to RELEASE.
  - request changes are ignored in BUSY.
- RELEASE: granted=0 and bus_busy=0 for exactly one cycle (bus turnaround), then IDLE. The earliest new grant is 2 cycles after the end strobe.
- begin_transaction while not in GRANT_WAIT: ignored. end_transaction or error outside BUSY/GRANT_WAIT: ignored.
- Counter width is $clog2(max(GRANT_TIMEOUT,BUS_TIMEOUT))+1. The counter saturates and never wraps.
- Reset mid-transaction: all state returns to reset values on the next edge. No timeout_error pulse.
- granted is one-hot or zero at all times. active_master holds its last value when granted=0.

Test Plan:
- Single master: request=4'b0100 at cycle 0 -> granted=4'b0100 at cycle 1, active_master=2; begin at 3, end at 6 -> granted=0 at 7 (RELEASE), IDLE at 8.
- Fairness: request=4'b1111 held, each transaction 3 cycles -> grant order 0,1,2,3,0. No master gets two consecutive grants while others request.
- Grant timeout: GRANT_TIMEOUT=16, master 1 granted at cycle 1 and never begins -> granted=0 at cycle 17. timeout_error stays 0. Next requester granted at cycle 18.
- Bus timeout: BUS_TIMEOUT=1024, begin at cycle 3, no end -> timeout_error=1 for one cycle at cycle 1027, granted=0 the same cycle.
- Simultaneous begin+end in GRANT_WAIT -> RELEASE next cycle. Error during BUSY behaves like end, with no timeout_error.
- Reset asserted while BUSY with granted=4'b1000 -> next cycle granted=0, bus_busy=0. After release, request=4'b1001 -> master 0 granted (pointer reset).
